mul_partial_accumulator: RTL and testbench
==========================================

// Module: mul_partial_accumulator
// PURPOSE
//  Downstream stage of the RV32M byte-sliced multiplier. Each cycle it takes the four 16-bit
//  lane products plus per-lane byte offsets from the multiplier datapath and accumulates them
//  into a 64-bit product register. After the final beat it selects the high or low word
//  (MULH*/MUL) into result_o and pulses done_o for one cycle.
// PARAMETERS
//  PP_W      16  width of each lane partial product
//  SHIFT_W   3   width of each lane byte-offset field (offset = value*8 bits)
//  ACC_W     64  accumulator width (full 32x32 product)
//  MAX_BEATS 4   beats after which the operation completes even without last_i
// PORTS
//  clk_i        in   1      clock, rising edge
//  rst_ni       in   1      asynchronous reset, active low
//  start_i      in   1      begin new operation: clear accumulator, latch upper_i
//  upper_i      in   1      1: result = acc[63:32]; 0: result = acc[31:0]; sampled on start_i
//  pp_valid_i   in   1      lane products/offsets valid this cycle
//  last_i       in   1      final beat of current operation; qualified by pp_valid_i
//  pp_signed_i  in   4      bit k=1: sign-extend ppk_i to ACC_W; 0: zero-extend
//  pp0_i..pp3_i in   16     lane partial products
//  sh0_i..sh3_i in   3      lane byte offsets
//  result_o     out  32     selected product word; holds until next completion
//  done_o       out  1      one-cycle pulse, result_o valid in the same cycle
//  busy_o       out  1      1 while in ACCUM
//  beat_cnt_o   out  3      beats accepted in current operation
// BEHAVIOUR
//  Reset (rst_ni=0, async): state IDLE, acc=0, result_o=0, done_o=0, busy_o=0, beat_cnt_o=0,
//   upper latch=0. A reset mid-operation discards all accumulated data; no done_o is produced.
//  FSM: IDLE -> ACCUM on start_i. ACCUM -> DONE on accepted beat with last_i=1 or
//   beat_cnt_o==MAX_BEATS-1. DONE -> IDLE unconditionally after one cycle.
//  start_i has priority in every state: acc<=0, beat_cnt<=0, upper latched, state<=ACCUM;
//   any beat presented in the same cycle is discarded. start_i in ACCUM aborts and restarts
//   the operation; the aborted one produces no done_o.
//  Beat accept: state==ACCUM && pp_valid_i && !start_i. Then
//   acc <= acc + sum_k( ext_k(ppk_i) << (8*shk_i) ), all terms and the sum taken mod 2^ACC_W;
//   bits shifted past bit 63 are dropped. beat_cnt_o increments by 1.
//  pp_valid_i in IDLE or DONE is ignored; last_i without pp_valid_i is ignored.
//  Completion: in the cycle the state is DONE, done_o=1, busy_o=0, and result_o already
//   holds the selected word of the final accumulator value (registered on the edge that
//   accepted the last beat). Latency: done_o asserts exactly 1 cycle after the final
//   accepted beat.
//  done_o is 0 in every cycle other than DONE. result_o changes only at completion.
//  busy_o=1 exactly while state==ACCUM. beat_cnt_o holds its value through DONE/IDLE until
//   the next start_i.
//  The accumulator is internal; only result_o is visible.
// TESTING
//  T1 start(upper=0); beat pp0=0x1234 sh0=0, pp1=0x0001 sh1=2, pp2=pp3=0, signed=0, last
//     -> next cycle done_o=1, result_o=0x00011234, beat_cnt_o=1
//  T2 start(upper=1); beat pp0=0xFFFF sh0=0, signed=4'b0001, others 0, last -> result_o=0xFFFFFFFF;
//     same stimulus with signed=0 -> result_o=0x00000000
//  T3 start(upper=1); 2 beats pp3=0xFFFF sh3=7 unsigned, last on 2nd
//     -> result_o=0xFE000000 (overflow above bit 63 dropped)
//  T4 start(upper=0); 4 beats pp0=0x0001 sh0=0, last_i never set -> done_o 1 cycle after 4th
//     beat, result_o=0x00000004, beat_cnt_o=4; a 5th pp_valid_i is ignored
//  T5 start; 2 beats pp0=0x00FF; start again (with beat 0x0F00 on same cycle); 1 beat
//     pp0=0x0001 last -> single done_o, result_o=0x00000001
//  T6 start; 2 beats; rst_ni low 1 cycle -> all outputs 0 asynchronously, no done_o;
//     new operation afterwards matches T1

Source files
------------

// File: rtl/mul_partial_accumulator_if.sv
// Handshake bundle between the multiplier datapath (master) and the partial-product
// accumulator (slave).
interface mul_partial_accumulator_if #(
    parameter int PP_W    = 16,
    parameter int SHIFT_W = 3
);
    logic               start_i;
    logic               upper_i;
    logic               pp_valid_i;
    logic               last_i;
    logic [3:0]         pp_signed_i;
    logic [PP_W-1:0]    pp0_i;
    logic [PP_W-1:0]    pp1_i;
    logic [PP_W-1:0]    pp2_i;
    logic [PP_W-1:0]    pp3_i;
    logic [SHIFT_W-1:0] sh0_i;
    logic [SHIFT_W-1:0] sh1_i;
    logic [SHIFT_W-1:0] sh2_i;
    logic [SHIFT_W-1:0] sh3_i;
    logic [31:0]        result_o;
    logic               done_o;
    logic               busy_o;
    logic [2:0]         beat_cnt_o;

    modport master (
        output start_i, upper_i, pp_valid_i, last_i, pp_signed_i,
        output pp0_i, pp1_i, pp2_i, pp3_i, sh0_i, sh1_i, sh2_i, sh3_i,
        input  result_o, done_o, busy_o, beat_cnt_o
    );

    modport slave (
        input  start_i, upper_i, pp_valid_i, last_i, pp_signed_i,
        input  pp0_i, pp1_i, pp2_i, pp3_i, sh0_i, sh1_i, sh2_i, sh3_i,
        output result_o, done_o, busy_o, beat_cnt_o
    );
endinterface

// File: rtl/mul_partial_accumulator.sv
// Accumulates four shifted lane products per beat into a 64-bit product and
// publishes the selected word with a one-cycle done pulse.
module mul_partial_accumulator #(
    parameter int PP_W      = 16,
    parameter int SHIFT_W   = 3,
    parameter int ACC_W     = 64,
    parameter int MAX_BEATS = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    mul_partial_accumulator_if.slave bus,
    output logic [1:0] dbg_state_o
);
    // Handshake: a beat transfers when pp_valid_i is high in a cycle the block is
    // in ACCUM and start_i is low; there is no backpressure, so ACCUM is the ready.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [31:0]        result_q, result_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic [2:0]         beat_cnt_q, beat_cnt_d;
    logic               upper_q, upper_d;

    logic [PP_W-1:0]    lane_pp [4];
    logic [SHIFT_W-1:0] lane_sh [4];
    logic [ACC_W-1:0]   lane_ext;
    logic [ACC_W-1:0]   beat_sum;
    logic [ACC_W-1:0]   acc_next;
    logic               beat_accept;
    logic               beat_final;

    always_comb begin
        lane_pp[0] = bus.pp0_i;
        lane_pp[1] = bus.pp1_i;
        lane_pp[2] = bus.pp2_i;
        lane_pp[3] = bus.pp3_i;
        lane_sh[0] = bus.sh0_i;
        lane_sh[1] = bus.sh1_i;
        lane_sh[2] = bus.sh2_i;
        lane_sh[3] = bus.sh3_i;
        lane_ext   = '0;
        beat_sum   = '0;
        // Bits pushed past the top of the accumulator simply fall off the shift.
        for (int k = 0; k < 4; k++) begin
            if (bus.pp_signed_i[k]) begin
                lane_ext = {{(ACC_W-PP_W){lane_pp[k][PP_W-1]}}, lane_pp[k]};
            end else begin
                lane_ext = {{(ACC_W-PP_W){1'b0}}, lane_pp[k]};
            end
            beat_sum = beat_sum + (lane_ext << {lane_sh[k], 3'b000});
        end
        acc_next = acc_q + beat_sum;
    end

    assign beat_accept = (state_q == ACCUM) && bus.pp_valid_i && !bus.start_i;
    assign beat_final  = bus.last_i || (beat_cnt_q == 3'(MAX_BEATS - 1));

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        result_d   = result_q;
        beat_cnt_d = beat_cnt_q;
        upper_d    = upper_q;
        if (bus.start_i) begin
            state_d    = ACCUM;
            acc_d      = '0;
            beat_cnt_d = '0;
            upper_d    = bus.upper_i;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (beat_accept) begin
                        acc_d      = acc_next;
                        beat_cnt_d = beat_cnt_q + 3'd1;
                        if (beat_final) begin
                            state_d  = DONE;
                            result_d = upper_q ? acc_next[ACC_W-1:ACC_W/2]
                                               : acc_next[ACC_W/2-1:0];
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        // Outputs are registered alongside the state so they line up with it.
        done_d = (state_d == DONE);
        busy_d = (state_d == ACCUM);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            result_q   <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            beat_cnt_q <= '0;
            upper_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            result_q   <= result_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            beat_cnt_q <= beat_cnt_d;
            upper_q    <= upper_d;
        end
    end

    assign bus.result_o   = result_q;
    assign bus.done_o     = done_q;
    assign bus.busy_o     = busy_q;
    assign bus.beat_cnt_o = beat_cnt_q;
    assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_mul_partial_accumulator.sv
// Scoreboarded bench for mul_partial_accumulator: directed operations plus random ones.
module tb_mul_partial_accumulator;
  logic clk;
  logic rst_n;
  logic [1:0] dbg_state;

  mul_partial_accumulator_if bus ();

  mul_partial_accumulator dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int n_done = 0;
  int n_exp_done = 0;
  logic [31:0] exp_q[$];
  logic [2:0]  cnt_q[$];

  // reference model state
  logic        m_active = 1'b0;
  logic        m_upper = 1'b0;
  logic [63:0] m_acc = '0;
  int          m_cnt = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] term(input logic [15:0] pp, input logic [2:0] sh, input logic sg);
    logic [63:0] e;
    e = sg ? {{48{pp[15]}}, pp} : {48'd0, pp};
    return e << (8 * sh);
  endfunction

  // drivers
  task automatic clear_inputs();
    bus.start_i = 1'b0;  bus.upper_i = 1'b0;  bus.pp_valid_i = 1'b0;  bus.last_i = 1'b0;
    bus.pp_signed_i = 4'd0;
    bus.pp0_i = '0;  bus.pp1_i = '0;  bus.pp2_i = '0;  bus.pp3_i = '0;
    bus.sh0_i = '0;  bus.sh1_i = '0;  bus.sh2_i = '0;  bus.sh3_i = '0;
  endtask

  task automatic do_start(input logic up);
    @(posedge clk); #1;
    clear_inputs();
    bus.start_i = 1'b1;
    bus.upper_i = up;
    m_active = 1'b1;  m_upper = up;  m_acc = '0;  m_cnt = 0;
  endtask

  task automatic do_beat(input logic [15:0] p0, p1, p2, p3, input logic [2:0] s0, s1, s2, s3,
                         input logic [3:0] sg, input logic lst);
    @(posedge clk); #1;
    clear_inputs();
    bus.pp_valid_i = 1'b1;  bus.last_i = lst;  bus.pp_signed_i = sg;
    bus.pp0_i = p0;  bus.pp1_i = p1;  bus.pp2_i = p2;  bus.pp3_i = p3;
    bus.sh0_i = s0;  bus.sh1_i = s1;  bus.sh2_i = s2;  bus.sh3_i = s3;
    if (m_active) begin
      m_acc = m_acc + term(p0, s0, sg[0]) + term(p1, s1, sg[1])
                    + term(p2, s2, sg[2]) + term(p3, s3, sg[3]);
      m_cnt++;
      if (lst || m_cnt == 4) begin
        exp_q.push_back(m_upper ? m_acc[63:32] : m_acc[31:0]);
        cnt_q.push_back(3'(m_cnt));
        n_exp_done++;
        m_active = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      clear_inputs();
    end
  endtask

  // Waits a bounded number of cycles for done_o after the final beat was driven.
  task automatic wait_done(input string tag);
    int waited;
    logic seen;
    seen = 1'b0;
    waited = 0;
    @(posedge clk); #1;
    clear_inputs();
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      if (bus.done_o) seen = 1'b1;
      else waited++;
    end
    check({tag, "_seen"}, seen, 1'b1);
    check({tag, "_lat"}, waited, 0);
    check({tag, "_busy"}, bus.busy_o, 1'b0);
    check({tag, "_st"}, dbg_state, 2'd2);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && bus.done_o) begin
      n_done++;
      if (exp_q.size() == 0) begin
        check("unexp_done", 1'b1, 1'b0);
      end else begin
        check("sb_result", bus.result_o, exp_q.pop_front());
        check("sb_cnt", bus.beat_cnt_o, cnt_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rp[4];
    logic [2:0]  rs[4];
    int nb;
    logic lst;
    clear_inputs();
    rst_n = 1'b0;
    #12;
    check("rst_result", bus.result_o, 32'd0);
    check("rst_done", bus.done_o, 1'b0);
    check("rst_busy", bus.busy_o, 1'b0);
    check("rst_cnt", bus.beat_cnt_o, 3'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // T1
    do_start(1'b0);
    @(negedge clk);
    do_beat(16'h1234, 16'h0001, 16'h0, 16'h0, 3'd0, 3'd2, 3'd0, 3'd0, 4'b0000, 1'b1);
    @(negedge clk);
    check("t1_busy", bus.busy_o, 1'b1);
    wait_done("t1");
    check("t1_res", bus.result_o, 32'h0001_1234);
    check("t1_cnt", bus.beat_cnt_o, 3'd1);
    @(negedge clk);
    check("t1_pulse", bus.done_o, 1'b0);
    check("t1_hold", bus.result_o, 32'h0001_1234);

    // T2
    do_start(1'b1);
    do_beat(16'hFFFF, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0, 3'd0, 3'd0, 4'b0001, 1'b1);
    wait_done("t2s");
    check("t2s_res", bus.result_o, 32'hFFFF_FFFF);
    do_start(1'b1);
    do_beat(16'hFFFF, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0, 3'd0, 3'd0, 4'b0000, 1'b1);
    wait_done("t2u");
    check("t2u_res", bus.result_o, 32'h0000_0000);

    // T3
    do_start(1'b1);
    do_beat(16'h0, 16'h0, 16'h0, 16'hFFFF, 3'd0, 3'd0, 3'd0, 3'd7, 4'b0000, 1'b0);
    do_beat(16'h0, 16'h0, 16'h0, 16'hFFFF, 3'd0, 3'd0, 3'd0, 3'd7, 4'b0000, 1'b1);
    wait_done("t3");
    check("t3_res", bus.result_o, 32'hFE00_0000);

    // T4
    do_start(1'b0);
    for (int b = 0; b < 4; b++)
      do_beat(16'h0001, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0, 3'd0, 3'd0, 4'b0000, 1'b0);
    wait_done("t4");
    check("t4_res", bus.result_o, 32'h0000_0004);
    check("t4_cnt", bus.beat_cnt_o, 3'd4);
    do_beat(16'h0001, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0, 3'd0, 3'd0, 4'b0000, 1'b1);
    idle(2);
    @(negedge clk);
    check("t4_5th_cnt", bus.beat_cnt_o, 3'd4);
    check("t4_5th_res", bus.result_o, 32'h0000_0004);

    // T5
    do_start(1'b0);
    do_beat(16'h00FF, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0, 3'd0, 3'd0, 4'b0000, 1'b0);
    do_beat(16'h00FF, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0, 3'd0, 3'd0, 4'b0000, 1'b0);
    do_start(1'b0);
    bus.pp_valid_i = 1'b1;
    bus.pp0_i = 16'h0F00;
    do_beat(16'h0001, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0, 3'd0, 3'd0, 4'b0000, 1'b1);
    wait_done("t5");
    check("t5_res", bus.result_o, 32'h0000_0001);
    check("t5_cnt", bus.beat_cnt_o, 3'd1);

    // T6
    do_start(1'b1);
    do_beat(16'h1111, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0, 3'd0, 3'd0, 4'b0000, 1'b0);
    do_beat(16'h2222, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0, 3'd0, 3'd0, 4'b0000, 1'b0);
    @(posedge clk); #1;
    clear_inputs();
    rst_n = 1'b0;
    m_active = 1'b0;
    #1;
    check("t6_result", bus.result_o, 32'd0);
    check("t6_busy", bus.busy_o, 1'b0);
    check("t6_cnt", bus.beat_cnt_o, 3'd0);
    check("t6_done", bus.done_o, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);
    do_start(1'b0);
    do_beat(16'h1234, 16'h0001, 16'h0, 16'h0, 3'd0, 3'd2, 3'd0, 3'd0, 4'b0000, 1'b1);
    wait_done("t6");
    check("t6_res", bus.result_o, 32'h0001_1234);

    // random operations, checked through the scoreboard
    for (int op = 0; op < 12; op++) begin
      do_start(1'($urandom_range(0, 1)));
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        for (int k = 0; k < 4; k++) begin
          rp[k] = 16'($urandom_range(0, 65535));
          rs[k] = 3'($urandom_range(0, 7));
        end
        lst = (b == nb - 1) && (nb < 4 || $urandom_range(0, 1) == 1);
        do_beat(rp[0], rp[1], rp[2], rp[3], rs[0], rs[1], rs[2], rs[3],
                4'($urandom_range(0, 15)), lst);
      end
      wait_done("rnd");
      idle($urandom_range(0, 2));
    end

    idle(3);
    check("drain", exp_q.size(), 0);
    check("done_count", n_done, n_exp_done);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
